nubus_master_burst: RTL and testbench

// Next-generation NuBus master sequencer for the test card. It arbitrates for the bus and

---
 rtl/nubus_master_burst_if.sv | 37 +++
 rtl/nubus_master_burst.sv | 164 ++++++++++++++++
 tb/tb_nubus_master_burst.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/nubus_master_burst_if.sv
// NuBus master sequencer bus/card bundle.
// Master drives the registered cycle strobes; the rest are bus and card inputs.
interface nubus_master_burst_if;
  logic       nub_rqstn;
  logic       nub_startn;
  logic       nub_ackn;
  logic [1:0] nub_tmn;
  logic       arb_grant;
  logic       cpu_req;
  logic       cpu_lock;
  logic [2:0] cpu_blk_log2;
  logic       mst_arbcyn_o;
  logic       mst_adrcyn_o;
  logic       mst_dtacyn_o;
  logic       mst_ownern_o;
  logic       mst_lockedn_o;
  logic       mst_beat;
  logic [3:0] mst_beat_idx;
  logic       mst_done;
  logic [1:0] mst_status;

  modport master (
    input  nub_rqstn, nub_startn, nub_ackn, nub_tmn,
    input  arb_grant, cpu_req, cpu_lock, cpu_blk_log2,
    output mst_arbcyn_o, mst_adrcyn_o, mst_dtacyn_o,
    output mst_ownern_o, mst_lockedn_o,
    output mst_beat, mst_beat_idx, mst_done, mst_status
  );

  modport slave (
    output nub_rqstn, nub_startn, nub_ackn, nub_tmn,
    output arb_grant, cpu_req, cpu_lock, cpu_blk_log2,
    input  mst_arbcyn_o, mst_adrcyn_o, mst_dtacyn_o,
    input  mst_ownern_o, mst_lockedn_o,
    input  mst_beat, mst_beat_idx, mst_done, mst_status
  );
endinterface

// File: rtl/nubus_master_burst.sv
// NuBus master sequencer: arbitration, address/data cycles, block
// transfers, try-again-later retries and ACK timeout.
module nubus_master_burst #(
  parameter int MAX_BLK_LOG2 = 2,
  parameter int RETRY_MAX    = 3,
  parameter int ACK_TMO      = 255
) (
  input logic nub_clkn,
  input logic nub_reset,
  nubus_master_burst_if.master bus
);

  localparam int TW = $clog2(ACK_TMO + 1);

  typedef enum logic [2:0] {
    IDLE, ARB, ARBDN, ADDR, DATA, LOCKED, REARB
  } state_t;

  state_t state, state_d;

  logic          rqst, start, ack;
  logic [1:0]    tm;
  logic          bus_busy;
  logic          own, own_d;
  logic          lock_q, lock_d;
  logic [2:0]    blk_q, blk_d, blk_req;
  logic [3:0]    retry_q, retry_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [3:0]    idx_q, idx_d, idx_lim;
  logic          beat_d, done_d;
  logic [1:0]    status_d;

  assign rqst  = ~bus.nub_rqstn;
  assign start = ~bus.nub_startn;
  assign ack   = ~bus.nub_ackn;
  assign tm    = ~bus.nub_tmn;

  assign blk_req = (bus.cpu_blk_log2 > 3'(MAX_BLK_LOG2)) ?
                   3'(MAX_BLK_LOG2) : bus.cpu_blk_log2;
  assign idx_lim = 4'((5'd1 << blk_q) - 5'd1);

  assign own   = state inside {ADDR, DATA, LOCKED};
  assign own_d = state_d inside {ADDR, DATA, LOCKED};

  always_comb begin
    state_d  = state;
    lock_d   = lock_q;
    blk_d    = blk_q;
    retry_d  = retry_q;
    tmr_d    = '0;
    idx_d    = idx_q;
    beat_d   = 1'b0;
    done_d   = 1'b0;
    status_d = bus.mst_status;
    case (state)
      IDLE: begin
        if (bus.cpu_req && !rqst) begin
          state_d = ARB;
          lock_d  = bus.cpu_lock;
          blk_d   = blk_req;
          retry_d = '0;
          idx_d   = '0;
        end
      end
      ARB: begin
        if (!start) state_d = ARBDN;
      end
      ARBDN: begin
        if (bus.arb_grant &&
            ((!bus_busy && !start) || (bus_busy && ack)))
          state_d = ADDR;
        else if (start && !bus.arb_grant)
          state_d = ARB;
      end
      ADDR: state_d = DATA;
      DATA: begin
        // Final ACK outranks an intermediate TM0 beat.
        if (ack) begin
          beat_d = 1'b1;
          if (tm == 2'b11) begin
            if (retry_q < 4'(RETRY_MAX)) begin
              retry_d = retry_q + 4'd1;
              idx_d   = '0;
              state_d = REARB;
            end else begin
              done_d   = 1'b1;
              status_d = 2'b11;
              state_d  = IDLE;
            end
          end else begin
            done_d   = 1'b1;
            status_d = tm;
            state_d  = (lock_q && bus.cpu_lock) ? LOCKED : IDLE;
          end
        end else if (tm[0]) begin
          beat_d = 1'b1;
          if (idx_q < idx_lim) idx_d = idx_q + 4'd1;
        end else if (tmr_q == TW'(ACK_TMO - 1)) begin
          done_d   = 1'b1;
          status_d = 2'b10;
          state_d  = IDLE;
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end
      LOCKED: begin
        if (!bus.cpu_lock) begin
          state_d = IDLE;
        end else if (bus.cpu_req) begin
          state_d = ADDR;
          blk_d   = blk_req;
          idx_d   = '0;
        end
      end
      REARB: begin
        if (!rqst) state_d = ARB;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge nub_clkn) begin
    if (nub_reset) begin
      state              <= IDLE;
      lock_q             <= 1'b0;
      blk_q              <= '0;
      retry_q            <= '0;
      tmr_q              <= '0;
      idx_q              <= '0;
      bus_busy           <= 1'b0;
      bus.mst_arbcyn_o   <= 1'b1;
      bus.mst_adrcyn_o   <= 1'b1;
      bus.mst_dtacyn_o   <= 1'b1;
      bus.mst_ownern_o   <= 1'b1;
      bus.mst_lockedn_o  <= 1'b1;
      bus.mst_beat       <= 1'b0;
      bus.mst_beat_idx   <= '0;
      bus.mst_done       <= 1'b0;
      bus.mst_status     <= '0;
    end else begin
      state    <= state_d;
      lock_q   <= lock_d;
      blk_q    <= blk_d;
      retry_q  <= retry_d;
      tmr_q    <= tmr_d;
      idx_q    <= idx_d;
      if (ack)
        bus_busy <= 1'b0;
      else if (start && !own)
        bus_busy <= 1'b1;
      bus.mst_arbcyn_o  <= !(state_d inside {ARB, ARBDN});
      bus.mst_adrcyn_o  <= !(state_d == ADDR);
      bus.mst_dtacyn_o  <= !(state_d == DATA);
      bus.mst_ownern_o  <= !own_d;
      bus.mst_lockedn_o <= !(own_d && lock_d);
      bus.mst_beat      <= beat_d;
      // Index of the beat just accepted, aligned with mst_beat.
      bus.mst_beat_idx  <= idx_q;
      bus.mst_done      <= done_d;
      bus.mst_status    <= status_d;
    end
  end

endmodule

// File: tb/tb_nubus_master_burst.sv
// Directed bench for nubus_master_burst: single, block, retry,
// timeout, locked and lost-arbitration/reset scenarios.
module tb_nubus_master_burst;

  logic clk = 1'b0;
  logic rst;

  nubus_master_burst_if bus ();

  nubus_master_burst #(
    .MAX_BLK_LOG2(2),
    .RETRY_MAX(3),
    .ACK_TMO(8)
  ) dut (
    .nub_clkn(clk),
    .nub_reset(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int n_arb, n_adr, n_dta, n_beat, n_done, n_lk, n_steps;
  int nb;
  int bl [16];
  int exp_bl [6];
  int guard;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    n_arb = 0; n_adr = 0; n_dta = 0; n_beat = 0;
    n_done = 0; n_lk = 0; n_steps = 0; nb = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    n_steps++;
    if (!bus.mst_arbcyn_o) n_arb++;
    if (!bus.mst_adrcyn_o) n_adr++;
    if (!bus.mst_dtacyn_o) n_dta++;
    if (!bus.mst_lockedn_o) n_lk++;
    if (bus.mst_done) n_done++;
    if (bus.mst_beat) begin
      if (nb < 16) bl[nb] = int'(bus.mst_beat_idx);
      nb++;
    end
  endtask

  // From IDLE (cpu_req set by caller) or REARB to the ADDR cycle.
  task automatic go_addr();
    bus.arb_grant = 1'b1;
    step();
    bus.cpu_req = 1'b0;
    step();
    step();
    bus.arb_grant = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst              = 1'b1;
    bus.nub_rqstn    = 1'b1;
    bus.nub_startn   = 1'b1;
    bus.nub_ackn     = 1'b1;
    bus.nub_tmn      = 2'b11;
    bus.arb_grant    = 1'b0;
    bus.cpu_req      = 1'b0;
    bus.cpu_lock     = 1'b0;
    bus.cpu_blk_log2 = 3'd0;
    clr();
    step();
    step();
    rst = 1'b0;
    chk("reset_outs", {bus.mst_arbcyn_o, bus.mst_adrcyn_o,
        bus.mst_dtacyn_o, bus.mst_ownern_o, bus.mst_lockedn_o,
        bus.mst_beat, bus.mst_done}, 7'b1111100);
    chk("reset_status", bus.mst_status, 2'b00);
    chk("reset_idx", bus.mst_beat_idx, 4'd0);

    // Single transfer, with a fairness wait while RQST is held
    clr();
    bus.nub_rqstn = 1'b0;
    bus.cpu_req   = 1'b1;
    step();
    chk("fair_wait", bus.mst_arbcyn_o, 1'b1);
    bus.nub_rqstn = 1'b1;
    clr();
    go_addr();
    repeat (4) step();
    bus.nub_ackn = 1'b0;
    bus.nub_tmn  = 2'b11;
    step();
    chk("t1_done", bus.mst_done, 1'b1);
    chk("t1_status", bus.mst_status, 2'b00);
    bus.nub_ackn = 1'b1;
    step();
    chk("t1_arb", n_arb, 2);
    chk("t1_adr", n_adr, 1);
    chk("t1_dta", n_dta, 4);
    chk("t1_beat", n_beat + nb, 1);
    chk("t1_ndone", n_done, 1);

    // Block of four beats
    clr();
    bus.cpu_req      = 1'b1;
    bus.cpu_blk_log2 = 3'd2;
    go_addr();
    bus.nub_tmn = 2'b10;
    step();
    repeat (3) step();
    bus.nub_ackn = 1'b0;
    bus.nub_tmn  = 2'b11;
    step();
    chk("t2_done", bus.mst_done, 1'b1);
    chk("t2_status", bus.mst_status, 2'b00);
    bus.nub_ackn = 1'b1;
    step();
    chk("t2_nbeat", nb, 4);
    for (int i = 0; i < 4; i++) chk("t2_idx", bl[i], i);

    // Oversized block is clamped; ack wins over TM0, status error
    clr();
    bus.cpu_req      = 1'b1;
    bus.cpu_blk_log2 = 3'd7;
    go_addr();
    bus.nub_tmn = 2'b10;
    step();
    repeat (5) step();
    bus.nub_ackn = 1'b0;
    step();
    chk("t2b_done", bus.mst_done, 1'b1);
    chk("t2b_status", bus.mst_status, 2'b01);
    bus.nub_ackn = 1'b1;
    bus.nub_tmn  = 2'b11;
    step();
    chk("t2b_nbeat", nb, 6);
    exp_bl = '{0, 1, 2, 3, 3, 3};
    for (int i = 0; i < 6; i++) chk("t2b_idx", bl[i], exp_bl[i]);
    bus.cpu_blk_log2 = 3'd0;

    // Try-again-later on every ack until retries run out
    clr();
    bus.cpu_req = 1'b1;
    for (int r = 0; r < 4; r++) begin
      go_addr();
      bus.nub_ackn = 1'b0;
      bus.nub_tmn  = 2'b00;
      step();
      step();
      bus.nub_ackn = 1'b1;
      bus.nub_tmn  = 2'b11;
      if (r < 3) chk("t3_nodone", bus.mst_done, 1'b0);
      else begin
        chk("t3_done", bus.mst_done, 1'b1);
        chk("t3_status", bus.mst_status, 2'b11);
      end
    end
    step();
    chk("t3_starts", n_adr, 4);
    chk("t3_ndone", n_done, 1);

    // ACK timeout
    bus.cpu_req = 1'b1;
    go_addr();
    clr();
    step();
    guard = 0;
    while (!bus.mst_dtacyn_o && guard < 20) begin
      step();
      guard++;
    end
    chk("t4_dta", n_dta, 8);
    chk("t4_done", bus.mst_done, 1'b1);
    chk("t4_status", bus.mst_status, 2'b10);
    chk("t4_owner", bus.mst_ownern_o, 1'b1);
    step();

    // Locked tenure: two accesses, one arbitration
    clr();
    bus.cpu_req  = 1'b1;
    bus.cpu_lock = 1'b1;
    go_addr();
    chk("t5_lk_addr", bus.mst_lockedn_o, 1'b0);
    n_lk = 0;
    n_steps = 0;
    bus.nub_ackn = 1'b0;
    step();
    step();
    bus.nub_ackn = 1'b1;
    chk("t5_done1", bus.mst_done, 1'b1);
    chk("t5_own", bus.mst_ownern_o, 1'b0);
    bus.cpu_req = 1'b1;
    step();
    chk("t5_addr2", bus.mst_adrcyn_o, 1'b0);
    bus.cpu_req  = 1'b0;
    bus.nub_ackn = 1'b0;
    step();
    step();
    bus.nub_ackn = 1'b1;
    step();
    chk("t5_lk_all", n_lk, 6);
    chk("t5_steps", n_steps, 6);
    chk("t5_arb", n_arb, 2);
    chk("t5_adr", n_adr, 2);
    chk("t5_ndone", n_done, 2);
    bus.cpu_lock = 1'b0;
    step();
    chk("t5_rel", {bus.mst_lockedn_o, bus.mst_ownern_o}, 2'b11);

    // Lost arbitration to a foreign START, then reset during DATA
    bus.cpu_req = 1'b1;
    step();
    bus.cpu_req = 1'b0;
    step();
    bus.nub_startn = 1'b0;
    step();
    chk("t6_keep_rqst", bus.mst_arbcyn_o, 1'b0);
    step();
    bus.nub_startn = 1'b1;
    bus.arb_grant  = 1'b1;
    bus.nub_ackn   = 1'b0;
    step();
    bus.nub_ackn = 1'b1;
    chk("t6_lost", bus.mst_adrcyn_o, 1'b1);
    step();
    chk("t6_addr", bus.mst_adrcyn_o, 1'b0);
    bus.arb_grant = 1'b0;
    step();
    chk("t6_data", {bus.mst_dtacyn_o, bus.mst_ownern_o}, 2'b00);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t6_reset", {bus.mst_arbcyn_o, bus.mst_adrcyn_o,
        bus.mst_dtacyn_o, bus.mst_ownern_o, bus.mst_lockedn_o,
        bus.mst_beat, bus.mst_done}, 7'b1111100);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
